// File: rtl/note_recorder.sv
// Record/playback stage between the keyboard encoder and the display/tone stages.
// Live notes pass through in IDLE, are stored as run-length events in REC, and are replayed in PLAY.
module note_recorder #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DUR_W  = 12
) (
    input  logic              clk_1khz,
    input  logic              reset,
    input  logic              rec_btn,
    input  logic              play_btn,
    input  logic              stop_btn,
    input  logic [4:0]        live_music,
    input  logic [1:0]        live_rot,
    output logic [4:0]        music,
    output logic [1:0]        rotation,
    output logic [1:0]        mode,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    localparam int unsigned MUSIC_W = 5;
    localparam int unsigned ROT_W   = 2;
    localparam int unsigned WORD_W  = MUSIC_W + ROT_W + DUR_W;
    localparam logic [DUR_W-1:0]  DUR_MAX   = '1;
    localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_rec_q, r_play_q, r_stop_q;
    logic [MUSIC_W-1:0]  r_music, w_music_nxt;
    logic [ROT_W-1:0]    r_rot, w_rot_nxt;
    logic [ADDR_W:0]     r_count, w_count_nxt;
    logic                r_full, w_full_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [MUSIC_W-1:0]  r_cur_music, w_cur_music_nxt;
    logic [ROT_W-1:0]    r_cur_rot, w_cur_rot_nxt;
    logic [DUR_W-1:0]    r_dur, w_dur_nxt;
    logic [ADDR_W:0]     r_idx, w_idx_nxt;
    logic [DUR_W-1:0]    r_rem, w_rem_nxt;
    logic [WORD_W-1:0]   r_rd_q;
    logic [WORD_W-1:0]   r_mem [DEPTH];

    logic                w_live_ok;
    logic [MUSIC_W-1:0]  w_live_music;
    logic [ROT_W-1:0]    w_live_rot;
    logic                w_rec_edge, w_play_edge, w_stop_edge;
    logic                w_rec_start, w_play_start;
    logic                w_same, w_we, w_hit_last;
    logic                w_load, w_play_done;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [MUSIC_W-1:0]  w_rd_music;
    logic [ROT_W-1:0]    w_rd_rot;
    logic [DUR_W-1:0]    w_rd_dur;

    // Out-of-range codes collapse to silence everywhere downstream
    assign w_live_ok    = (live_music <= 5'd21) && (live_rot != 2'd3);
    assign w_live_music = w_live_ok ? live_music : '0;
    assign w_live_rot   = w_live_ok ? live_rot : '0;

    assign w_rec_edge  = rec_btn & ~r_rec_q;
    assign w_play_edge = play_btn & ~r_play_q;
    assign w_stop_edge = stop_btn & ~r_stop_q;

    assign w_rec_start  = (r_state == S_IDLE) && w_rec_edge && !w_stop_edge;
    assign w_play_start = (r_state == S_IDLE) && w_play_edge && !w_stop_edge && !w_rec_edge
                          && (r_count != '0);

    assign w_same     = (w_live_music == r_cur_music) && (w_live_rot == r_cur_rot);
    assign w_we       = (r_state == S_REC) && (w_stop_edge || !w_same || (r_dur == DUR_MAX));
    assign w_hit_last = w_we && (r_wr_ptr == LAST_ADDR);

    // Load the prefetched event when the current one is on its last cycle (or during lead-in)
    assign w_load      = (r_state == S_PLAY) && (r_rem <= DUR_ONE);
    assign w_play_done = w_load && (r_idx == r_count);

    // Address the event that the next load will consume so read latency never shows
    assign w_rd_addr = w_load                ? ADDR_W'(r_idx + CNT_ONE) :
                       (r_state == S_PLAY)   ? ADDR_W'(r_idx) : '0;

    assign w_rd_music = r_rd_q[WORD_W-1 -: MUSIC_W];
    assign w_rd_rot   = r_rd_q[DUR_W +: ROT_W];
    assign w_rd_dur   = r_rd_q[DUR_W-1:0];

    always_ff @(posedge clk_1khz or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rec_start)       w_state_nxt = S_REC;
                else if (w_play_start) w_state_nxt = S_PLAY;
            end
            S_REC:   if (w_stop_edge || w_hit_last)  w_state_nxt = S_IDLE;
            S_PLAY:  if (w_stop_edge || w_play_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_music_nxt     = w_live_music;
        w_rot_nxt       = w_live_rot;
        w_count_nxt     = r_count;
        w_full_nxt      = r_full;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_cur_music_nxt = r_cur_music;
        w_cur_rot_nxt   = r_cur_rot;
        w_dur_nxt       = r_dur;
        w_idx_nxt       = r_idx;
        w_rem_nxt       = r_rem;
        case (r_state)
            S_IDLE: begin
                if (w_rec_start) begin
                    w_count_nxt     = '0;
                    w_full_nxt      = 1'b0;
                    w_wr_ptr_nxt    = '0;
                    w_cur_music_nxt = w_live_music;
                    w_cur_rot_nxt   = w_live_rot;
                    w_dur_nxt       = DUR_ONE;
                end else if (w_play_start) begin
                    w_music_nxt = '0;
                    w_rot_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rem_nxt   = '0;
                end
            end
            S_REC: begin
                if (w_we) begin
                    w_count_nxt  = r_count + CNT_ONE;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    if (w_hit_last) w_full_nxt = 1'b1;
                end
                if (!w_same) begin
                    w_cur_music_nxt = w_live_music;
                    w_cur_rot_nxt   = w_live_rot;
                    w_dur_nxt       = DUR_ONE;
                end else if (r_dur == DUR_MAX) begin
                    w_dur_nxt = DUR_ONE;
                end else begin
                    w_dur_nxt = r_dur + DUR_ONE;
                end
            end
            S_PLAY: begin
                if (!(w_stop_edge || w_play_done)) begin
                    if (w_load) begin
                        w_music_nxt = w_rd_music;
                        w_rot_nxt   = w_rd_rot;
                        w_rem_nxt   = w_rd_dur;
                        w_idx_nxt   = r_idx + CNT_ONE;
                    end else begin
                        w_music_nxt = r_music;
                        w_rot_nxt   = r_rot;
                        w_rem_nxt   = r_rem - DUR_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_1khz or posedge reset) begin
        if (reset) begin
            r_rec_q     <= 1'b0;
            r_play_q    <= 1'b0;
            r_stop_q    <= 1'b0;
            r_music     <= '0;
            r_rot       <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_wr_ptr    <= '0;
            r_cur_music <= '0;
            r_cur_rot   <= '0;
            r_dur       <= '0;
            r_idx       <= '0;
            r_rem       <= '0;
            r_rd_q      <= '0;
        end else begin
            r_rec_q     <= rec_btn;
            r_play_q    <= play_btn;
            r_stop_q    <= stop_btn;
            r_music     <= w_music_nxt;
            r_rot       <= w_rot_nxt;
            r_count     <= w_count_nxt;
            r_full      <= w_full_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_cur_music <= w_cur_music_nxt;
            r_cur_rot   <= w_cur_rot_nxt;
            r_dur       <= w_dur_nxt;
            r_idx       <= w_idx_nxt;
            r_rem       <= w_rem_nxt;
            r_rd_q      <= r_mem[w_rd_addr];
        end
    end

    // Event RAM: contents are meaningful only below count, so no reset
    always_ff @(posedge clk_1khz) begin
        if (w_we) r_mem[r_wr_ptr] <= {r_cur_music, r_cur_rot, r_dur};
    end

    assign music    = r_music;
    assign rotation = r_rot;
    assign mode     = r_state;
    assign count    = r_count;
    assign full     = r_full;

endmodule
